// File: rtl/conv3x3_mc.sv
// conv3x3_mc: multi-channel 3x3 convolution, 3-stage pipeline with bias, ReLU and saturation
module conv3x3_mc #(
  parameter int NCH    = 3,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 22
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NCH*9*PIX_W-1:0]          i_pixel_data,
  input  logic                            i_pixel_data_valid,
  output logic                            o_pixel_data_ready,
  input  logic                            i_coef_wr_en,
  input  logic [$clog2(NCH*9+1)-1:0]      i_coef_wr_addr,
  input  logic [COEF_W-1:0]               i_coef_wr_data,
  input  logic                            i_relu_en,
  output logic signed [OUT_W-1:0]         o_convolved_data,
  output logic                            o_convolved_data_valid,
  output logic                            o_sat,
  input  logic                            i_out_ready
);
  localparam int NT = NCH*9;
  localparam int AW = $clog2(NT+1);
  localparam int PW = COEF_W+PIX_W+1;
  localparam int SW = PW+$clog2(NT);
  localparam int BW = (SW+1 > OUT_W+1) ? SW+1 : OUT_W+1;
  localparam logic signed [BW-1:0] MAXV = {{(BW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [BW-1:0] MINV = {{(BW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [COEF_W-1:0] r_coef [NT];
  logic signed [COEF_W-1:0] r_bias;
  logic signed [PW-1:0]     w_prod [NT];
  logic signed [PW-1:0]     r_prod [NT];
  logic signed [SW-1:0]     w_sum;
  logic signed [SW-1:0]     r_sum;
  logic signed [BW-1:0]     w_biased;
  logic signed [BW-1:0]     w_relu;
  logic                     w_hi;
  logic                     w_lo;
  logic                     w_en;
  logic                     r_v1;
  logic                     r_v2;

  assign w_en = !o_convolved_data_valid || i_out_ready;
  assign o_pixel_data_ready = w_en;

  // coefficient and bias writes land on any cycle, independent of the pipeline stall
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NT; i++) r_coef[i] <= '0;
      r_bias <= '0;
    end else if (i_coef_wr_en) begin
      for (int i = 0; i < NT; i++) if (i_coef_wr_addr == AW'(i)) r_coef[i] <= i_coef_wr_data;
      if (i_coef_wr_addr == AW'(NT)) r_bias <= i_coef_wr_data;
    end
  end

  // signed coefficient times zero-extended pixel, full precision
  always_comb begin
    for (int i = 0; i < NT; i++)
      w_prod[i] = PW'(r_coef[i]) * PW'($signed({1'b0, i_pixel_data[i*PIX_W +: PIX_W]}));
  end

  // stage 1: register all products
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      for (int i = 0; i < NT; i++) r_prod[i] <= '0;
    end else if (w_en) begin
      r_v1 <= i_pixel_data_valid;
      for (int i = 0; i < NT; i++) r_prod[i] <= w_prod[i];
    end
  end

  // per-channel 9-tap sums folded into the cross-channel total
  always_comb begin
    logic signed [SW-1:0] acc;
    w_sum = '0;
    for (int c = 0; c < NCH; c++) begin
      acc = '0;
      for (int t = 0; t < 9; t++) acc = acc + SW'(r_prod[c*9+t]);
      w_sum = w_sum + acc;
    end
  end

  // stage 2: register the total sum
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v2  <= 1'b0;
      r_sum <= '0;
    end else if (w_en) begin
      r_v2  <= r_v1;
      r_sum <= w_sum;
    end
  end

  // bias add, then ReLU, then clip detection
  always_comb begin
    w_biased = BW'(r_sum) + BW'(r_bias);
    w_relu   = (i_relu_en && w_biased[BW-1]) ? '0 : w_biased;
    w_hi     = w_relu > MAXV;
    w_lo     = w_relu < MINV;
  end

  // stage 3: saturated result to the outputs, held while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_convolved_data_valid <= 1'b0;
      o_convolved_data       <= '0;
      o_sat                  <= 1'b0;
    end else if (w_en) begin
      o_convolved_data_valid <= r_v2;
      o_convolved_data       <= w_hi ? MAXV[OUT_W-1:0] : w_lo ? MINV[OUT_W-1:0] : w_relu[OUT_W-1:0];
      o_sat                  <= w_hi || w_lo;
    end
  end
endmodule

// File: doc/conv3x3_mc.md
CONV3X3_MC -- requirements
Module: conv3x3_mc

Interface
REQ-001 Parameter NCH, 3, number of input channels (1..8).
REQ-002 Parameter PIX_W, 8, unsigned pixel width.
REQ-003 Parameter COEF_W, 16, signed two's-complement coefficient and bias width.
REQ-004 Parameter OUT_W, 22, signed output width (OUT_W >= 8).
REQ-005 One clock, i_clk; reset is asynchronous and active-low, i_rst_n.
REQ-006 i_clk  input  1  rising-edge clock for all state.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_pixel_data  input  NCH*9*PIX_W  3x3 windows; channel c, tap t (0..8, row-major) at bits [(c*9+t)*PIX_W +: PIX_W].
REQ-009 i_pixel_data_valid  input  1  window valid.
REQ-010 o_pixel_data_ready  output  1  block accepts a window this cycle.
REQ-011 i_coef_wr_en  input  1  coefficient/bias write strobe.
REQ-012 i_coef_wr_addr  input  clog2(NCH*9+1)  address c*9+t for coefficients; address NCH*9 for bias.
REQ-013 i_coef_wr_data  input  COEF_W  write data.
REQ-014 i_relu_en  input  1  clamp negative results to 0 when 1.
REQ-015 o_convolved_data  output  OUT_W  signed result.
REQ-016 o_convolved_data_valid  output  1  result valid.
REQ-017 o_sat  output  1  result was saturated; qualified by valid.
REQ-018 i_out_ready  input  1  downstream accepts result.

Function
REQ-019 Transfer in: i_pixel_data_valid && o_pixel_data_ready; transfer out: o_convolved_data_valid && i_out_ready.
REQ-020 Pipeline: 3 stages — S1 NCH*9 products registered, S2 per-channel sums plus cross-channel sum registered, S3 bias add, ReLU, saturate registered to outputs.
REQ-021 Latency: 3 cycles from input transfer to o_convolved_data_valid when not stalled; throughput 1 window/cycle.
REQ-022 Global enable en = !o_convolved_data_valid || i_out_ready; o_pixel_data_ready = en.
REQ-023 When en=0 all stages, including valid bits, hold; outputs stay stable until accepted.
REQ-024 Results emerge in input order; no window is dropped or duplicated.
REQ-025 Product = signed coef × zero-extended pixel, full precision, COEF_W+PIX_W+1 bits.
REQ-026 Accumulation is at full precision: COEF_W+PIX_W+1+clog2(9*NCH) bits; no intermediate truncation.
REQ-027 Bias is sign-extended and added once per window in S3.
REQ-028 ReLU is applied before saturation; with i_relu_en=1 a negative sum yields 0 and o_sat=0.
REQ-029 Saturation range is [-2^(OUT_W-1), 2^(OUT_W-1)-1]; clip to the nearest bound and set o_sat=1; otherwise o_sat=0.
REQ-030 i_relu_en is sampled in S3 of each window.
REQ-031 Coefficient writes are accepted on any cycle regardless of stall and update on the rising edge.
REQ-032 A window in S1 on the edge of a coefficient write uses the old coefficient; the bias applies similarly at S3.
REQ-033 Writes to addresses > NCH*9 are ignored.

Reset
REQ-034 i_rst_n=0 asynchronously clears all coefficients, bias, pipeline valids, o_convolved_data, o_sat and o_convolved_data_valid to 0.
REQ-035 Windows in flight at reset are discarded; no valid output is produced for them after release.
REQ-036 After release, o_pixel_data_ready=1 on the first cycle.

Verification
REQ-037 Basic: NCH=3, all channels coef [1,2,1,0,0,0,-1,-2,-1], bias 0, row0 taps=10, others 0, relu off -> output 120 exactly 3 cycles after transfer, o_sat=0.
REQ-038 ReLU: same coefs, row2 taps=10, others 0 -> -120 with relu off; 0 with relu on; bias 200 with relu on -> 80.
REQ-039 Saturation: OUT_W=12, all coefs 32767, all pixels 255 -> 2047, o_sat=1; all coefs -32768 -> -2048, o_sat=1.
REQ-040 Backpressure: 5 back-to-back windows, i_out_ready low for cycles 3-6 -> o_pixel_data_ready low while stalled, outputs held stable, all 5 results delivered in order.
REQ-041 Coef timing: write tap 0 of ch0 from 1 to 3 in the same cycle a window transfers, with pixel 10 at tap0 only -> that window gives 10×(old) and the next window gives 30.
REQ-042 Reset mid-stream: assert i_rst_n with 2 windows in flight -> outputs 0 immediately, coefficients zero, no stale valid after release, a next window yields bias-only 0.
